// File: rtl/layer_pkg.sv
// Shared types for the NU-array layer sequencer: descriptor layout and FSM states.
// The assembler and the testbench also import this package.
package layer_pkg;

    localparam int DEF_NU_COUNT   = 8;
    localparam int DEF_INST_DEPTH = 8;
    localparam int DEF_XY_DEPTH   = 10;
    localparam int DEF_W_DEPTH    = 10;
    localparam int DEF_LEN_W      = 10;
    localparam int DEF_ACT_MASK_W = 4;

    typedef struct packed {
        logic [DEF_XY_DEPTH-1:0]   x_offset;
        logic [DEF_LEN_W-1:0]      x_length;
        logic [DEF_XY_DEPTH-1:0]   y_offset;
        logic [DEF_LEN_W-1:0]      y_length;
        logic [DEF_W_DEPTH-1:0]    w_offset;
        logic [DEF_ACT_MASK_W-1:0] act_mask;
        logic                      output_layer;
        logic                      last;
    } Layer;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACC,
        DRAIN,
        PAUSE
    } SeqState;

endpackage

// File: rtl/seq_writeback_counter.sv
// Write-back side of the sequencer: counts down the outputs of a handed-off batch,
// walking xy_write_addr and holding the batch's activation mask and output select.
module seq_writeback_counter
    import layer_pkg::*;
#(
    parameter int XY_DEPTH   = DEF_XY_DEPTH,
    parameter int ACT_MASK_W = DEF_ACT_MASK_W,
    parameter int CNT_W      = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  load_first,
    input  logic [CNT_W-1:0]      load_count,
    input  logic [XY_DEPTH-1:0]   first_addr,
    input  logic [ACT_MASK_W-1:0] mask_in,
    input  logic                  select_in,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  xy_write_enable,
    output logic [XY_DEPTH-1:0]   xy_write_addr,
    output logic [ACT_MASK_W-1:0] act_mask,
    output logic                  xy_output_write_select
);

    assign xy_write_enable = (wr_count != '0);

    // The address rests on the last written location, so the next batch starts one past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count               <= '0;
            xy_write_addr          <= '0;
            act_mask               <= '0;
            xy_output_write_select <= 1'b0;
        end else if (clear) begin
            wr_count <= '0;
        end else if (load) begin
            wr_count               <= load_count;
            xy_write_addr          <= load_first ? first_addr : xy_write_addr + XY_DEPTH'(1);
            act_mask               <= mask_in;
            xy_output_write_select <= select_in;
        end else if (wr_count != '0) begin
            wr_count <= wr_count - CNT_W'(1);
            if (wr_count != CNT_W'(1))
                xy_write_addr <= xy_write_addr + XY_DEPTH'(1);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer controller for the NU array: fetches descriptors, walks x/w operands for MAC
// accumulation in batches of NU_COUNT outputs and hands each batch to the write-back counter.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int NU_COUNT   = DEF_NU_COUNT,
    parameter int INST_DEPTH = DEF_INST_DEPTH,
    parameter int XY_DEPTH   = DEF_XY_DEPTH,
    parameter int W_DEPTH    = DEF_W_DEPTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int ACT_MASK_W = DEF_ACT_MASK_W
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  step_mode,
    input  logic [INST_DEPTH-1:0] start_addr,
    output logic [INST_DEPTH-1:0] inst_read_addr,
    input  Layer                  inst_read_data,
    output logic                  mac_acc_update,
    output logic                  mac_acc_loopback,
    output logic                  serializer_update,
    output logic [XY_DEPTH-1:0]   xy_read_addr,
    output logic [W_DEPTH-1:0]    w_read_addr,
    output logic                  xy_write_enable,
    output logic [XY_DEPTH-1:0]   xy_write_addr,
    output logic                  xy_output_write_select,
    output logic [ACT_MASK_W-1:0] act_mask,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(NU_COUNT + 1);

    SeqState               state;
    Layer                  desc;
    logic [INST_DEPTH-1:0] pc;
    logic [XY_DEPTH-1:0]   x_ptr, x_end;
    logic [W_DEPTH-1:0]    w_ptr;
    logic [LEN_W-1:0]      batches_left, nb;
    logic [LEN_W:0]        nb_sum;
    logic                  first_batch, done_pend;
    logic [CNT_W-1:0]      wr_count, rem, load_count;
    logic                  skip, handoff, final_batch, layer_done, layer_last;

    assign nb_sum      = (LEN_W+1)'(inst_read_data.y_length) + (LEN_W+1)'(NU_COUNT - 1);
    assign nb          = LEN_W'(nb_sum / (LEN_W+1)'(NU_COUNT));
    assign skip        = (inst_read_data.x_length == '0) || (inst_read_data.y_length == '0);
    assign x_end       = desc.x_offset + XY_DEPTH'(desc.x_length) - XY_DEPTH'(1);
    assign final_batch = (batches_left == LEN_W'(1));
    assign rem         = CNT_W'(desc.y_length % LEN_W'(NU_COUNT));
    assign load_count  = (final_batch && rem != '0) ? rem : CNT_W'(NU_COUNT);
    assign handoff     = !abort && (wr_count <= CNT_W'(1)) &&
                         ((state == ACC && x_ptr == x_end) || state == DRAIN);
    assign layer_done  = (state == FETCH && skip) || (handoff && final_batch);
    assign layer_last  = (state == FETCH) ? inst_read_data.last : desc.last;

    // Address leads pc by one cycle so the descriptor is valid throughout FETCH.
    assign inst_read_addr    = (state == IDLE) ? (run ? start_addr : pc) : pc + INST_DEPTH'(1);
    assign mac_acc_update    = (state == ACC);
    assign mac_acc_loopback  = (x_ptr != desc.x_offset);
    assign serializer_update = handoff;
    assign xy_read_addr      = x_ptr;
    assign w_read_addr       = w_ptr;
    assign busy              = (state != IDLE) || (wr_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            desc         <= '0;
            x_ptr        <= '0;
            w_ptr        <= '0;
            batches_left <= '0;
            first_batch  <= 1'b0;
            done_pend    <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // done waits for the writer to issue the final batch's last write
            if (done_pend && wr_count <= CNT_W'(1)) begin
                done      <= 1'b1;
                done_pend <= 1'b0;
            end
            case (state)
                IDLE: if (run) begin
                    pc    <= start_addr;
                    state <= FETCH;
                end
                FETCH: begin
                    desc         <= inst_read_data;
                    x_ptr        <= inst_read_data.x_offset;
                    w_ptr        <= inst_read_data.w_offset;
                    batches_left <= nb;
                    first_batch  <= 1'b1;
                    if (!skip)
                        state <= ACC;
                end
                ACC: begin
                    x_ptr <= x_ptr + XY_DEPTH'(1);
                    w_ptr <= w_ptr + W_DEPTH'(1);
                    if (x_ptr == x_end && !handoff)
                        state <= DRAIN;
                end
                DRAIN: ;
                PAUSE: if (run) begin
                    pc    <= pc + INST_DEPTH'(1);
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
            if (handoff) begin
                first_batch  <= 1'b0;
                batches_left <= batches_left - LEN_W'(1);
                if (!final_batch) begin
                    x_ptr <= desc.x_offset;
                    state <= ACC;
                end
            end
            if (layer_done) begin
                if (layer_last) begin
                    state     <= IDLE;
                    done_pend <= 1'b1;
                end else if (step_mode) begin
                    state <= PAUSE;
                end else begin
                    pc    <= pc + INST_DEPTH'(1);
                    state <= FETCH;
                end
            end
        end
    end

    seq_writeback_counter #(
        .XY_DEPTH   (XY_DEPTH),
        .ACT_MASK_W (ACT_MASK_W),
        .CNT_W      (CNT_W)
    ) u_wb (
        .clk                    (clk),
        .reset                  (reset),
        .clear                  (abort),
        .load                   (handoff),
        .load_first             (first_batch),
        .load_count             (load_count),
        .first_addr             (desc.y_offset),
        .mask_in                (desc.act_mask),
        .select_in              (desc.output_layer),
        .wr_count               (wr_count),
        .xy_write_enable        (xy_write_enable),
        .xy_write_addr          (xy_write_addr),
        .act_mask               (act_mask),
        .xy_output_write_select (xy_output_write_select)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed and random descriptor programs checked against
// expected MAC-address, write-back and done streams computed from the layer rules.
module tb_layer_sequencer;
    import layer_pkg::*;

    localparam int NU = 8;

    logic       clk = 1'b0, reset = 1'b1, run = 1'b0, abort = 1'b0, step_mode = 1'b0;
    logic [7:0] start_addr = '0, inst_read_addr;
    Layer       inst_read_data;
    logic       mac_acc_update, mac_acc_loopback, serializer_update;
    logic [9:0] xy_read_addr, w_read_addr, xy_write_addr;
    logic       xy_write_enable, xy_output_write_select, busy, done;
    logic [3:0] act_mask;

    layer_sequencer #(.NU_COUNT(NU)) dut (
        .clk(clk), .reset(reset), .run(run), .abort(abort), .step_mode(step_mode),
        .start_addr(start_addr), .inst_read_addr(inst_read_addr), .inst_read_data(inst_read_data),
        .mac_acc_update(mac_acc_update), .mac_acc_loopback(mac_acc_loopback),
        .serializer_update(serializer_update), .xy_read_addr(xy_read_addr), .w_read_addr(w_read_addr),
        .xy_write_enable(xy_write_enable), .xy_write_addr(xy_write_addr),
        .xy_output_write_select(xy_output_write_select), .act_mask(act_mask), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    Layer mem [256];
    always @(posedge clk) inst_read_data <= mem[inst_read_addr];

    logic [31:0] exp_mac[$], exp_wr[$], obs_mac[$], obs_wr[$];
    int lay_mac_end[$], lay_wr_end[$];
    int exp_ser, ser_cnt = 0, done_cnt = 0, wr_at_done = 0;
    int n_cmp = 0, n_bad = 0;
    bit first_exec;

    always @(negedge clk) if (!reset) begin
        if (mac_acc_update) obs_mac.push_back({11'b0, mac_acc_loopback, xy_read_addr, w_read_addr});
        if (xy_write_enable) obs_wr.push_back({17'b0, xy_output_write_select, act_mask, xy_write_addr});
        if (serializer_update) ser_cnt++;
        if (done) begin
            done_cnt++;
            wr_at_done = obs_wr.size();
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic Layer mk(input int xo, xl, yo, yl, wo, am, ol, lst);
        Layer d;
        d.x_offset = 10'(xo); d.x_length = 10'(xl); d.y_offset = 10'(yo); d.y_length = 10'(yl);
        d.w_offset = 10'(wo); d.act_mask = 4'(am); d.output_layer = 1'(ol); d.last = 1'(lst);
        return d;
    endfunction

    // Batch b of a layer reads x_offset+i against weights w_offset + b*x_length + i;
    // outputs land at y_offset.. y_offset+y_length-1 in order.
    task automatic build_model(input logic [7:0] start);
        logic [7:0] pc;
        logic [9:0] xa, wa, ya;
        Layer d;
        int nb;
        exp_mac.delete(); exp_wr.delete(); lay_mac_end.delete(); lay_wr_end.delete();
        exp_ser = 0;
        pc = start;
        first_exec = (mem[start].x_length != 0) && (mem[start].y_length != 0);
        for (int g = 0; g < 256; g++) begin
            d = mem[pc];
            if (d.x_length != 0 && d.y_length != 0) begin
                nb = (int'(d.y_length) + NU - 1) / NU;
                exp_ser += nb;
                for (int b = 0; b < nb; b++)
                    for (int i = 0; i < int'(d.x_length); i++) begin
                        xa = d.x_offset + 10'(i);
                        wa = d.w_offset + 10'(b * int'(d.x_length) + i);
                        exp_mac.push_back({11'b0, (i != 0), xa, wa});
                    end
                for (int j = 0; j < int'(d.y_length); j++) begin
                    ya = d.y_offset + 10'(j);
                    exp_wr.push_back({17'b0, d.output_layer, d.act_mask, ya});
                end
            end
            lay_mac_end.push_back(exp_mac.size());
            lay_wr_end.push_back(exp_wr.size());
            if (d.last) break;
            pc++;
        end
    endtask

    task automatic run_prog(input logic [7:0] start, input bit step, input bit stray);
        int bm, bw, bs, bd, lat, t;
        build_model(start);
        bm = obs_mac.size(); bw = obs_wr.size(); bs = ser_cnt; bd = done_cnt;
        @(negedge clk);
        start_addr = start; step_mode = step; run = 1'b1;
        #1 chk("fetch_addr", inst_read_addr, start);
        @(negedge clk);
        run = 1'b0;
        if (first_exec) begin
            lat = 1;
            while (!mac_acc_update && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("run_latency", lat, 2);
        end
        if (stray && !step && exp_mac.size() > 12) begin
            repeat (3) @(negedge clk);
            run = 1'b1;
            @(negedge clk);
            run = 1'b0;
        end
        if (step)
            for (int k = 0; k < lay_mac_end.size() - 1; k++) begin
                t = 0;
                while ((obs_mac.size() - bm != lay_mac_end[k] || obs_wr.size() - bw != lay_wr_end[k])
                       && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                chk("step_layer_timeout", (t < 2000), 1);
                repeat (5) @(negedge clk);
                chk("pause_no_mac", obs_mac.size() - bm, lay_mac_end[k]);
                chk("pause_busy", busy, 1);
                run = 1'b1;
                @(negedge clk);
                run = 1'b0;
            end
        t = 0;
        while (done_cnt == bd && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - bd, 1);
        chk("writes_before_done", wr_at_done - bw, exp_wr.size());
        chk("busy_at_end", busy, 0);
        chk("serializer_count", ser_cnt - bs, exp_ser);
        chk("mac_count", obs_mac.size() - bm, exp_mac.size());
        chk("write_count", obs_wr.size() - bw, exp_wr.size());
        for (int k = 0; k < exp_mac.size(); k++)
            if (bm + k < obs_mac.size()) chk("mac_addr", obs_mac[bm + k], exp_mac[k]);
        for (int k = 0; k < exp_wr.size(); k++)
            if (bw + k < obs_wr.size()) chk("write", obs_wr[bw + k], exp_wr[k]);
    endtask

    initial begin
        int bm, bd, bw, t;
        logic [7:0] s, idx;
        int nl;
        Layer d;
        for (int i = 0; i < 256; i++) mem[i] = mk(0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac", mac_acc_update, 0);
        chk("rst_wen", xy_write_enable, 0);
        chk("rst_waddr", xy_write_addr, 0);
        chk("rst_mask", act_mask, 0);
        chk("rst_xaddr", xy_read_addr, 0);
        chk("rst_waddr_w", w_read_addr, 0);
        chk("rst_ser", serializer_update, 0);
        chk("rst_pc", inst_read_addr, 0);

        // two full batches, then a short final batch, then a writer-bound layer that drains
        mem[0] = mk(100, 4, 200, 16, 300, 4'ha, 1, 1);
        run_prog(8'd0, 1'b0, 1'b1);
        mem[10] = mk(1020, 3, 1018, 10, 1022, 4'h5, 0, 1);
        run_prog(8'd10, 1'b0, 1'b0);
        chk("final_write_addr", xy_write_addr, 10'(1018 + 9));
        mem[12] = mk(40, 2, 500, 24, 60, 4'h3, 1, 1);
        run_prog(8'd12, 1'b0, 1'b0);

        // step mode over three layers
        mem[20] = mk(1, 3, 100, 9, 7, 4'h1, 0, 0);
        mem[21] = mk(5, 2, 150, 8, 9, 4'h2, 1, 0);
        mem[22] = mk(9, 4, 180, 5, 3, 4'h4, 0, 1);
        run_prog(8'd20, 1'b1, 1'b0);

        // abort in the middle of layer 1
        mem[30] = mk(10, 3, 300, 8, 20, 4'h6, 0, 0);
        mem[31] = mk(30, 4, 400, 16, 40, 4'h7, 1, 1);
        bm = obs_mac.size(); bd = done_cnt;
        @(negedge clk);
        start_addr = 8'd30; step_mode = 1'b0; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        t = 0;
        while (!(mac_acc_update && obs_mac.size() - bm >= 6) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_timeout", (t < 500), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_mac", mac_acc_update, 0);
        chk("abort_wen", xy_write_enable, 0);
        chk("abort_busy", busy, 0);
        bw = obs_wr.size();
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - bd, 0);
        chk("abort_no_writes", obs_wr.size() - bw, 0);
        mem[5] = mk(70, 2, 600, 11, 90, 4'h9, 1, 1);
        run_prog(8'd5, 1'b0, 1'b0);

        // zero-length layer sandwiched between two valid ones
        mem[40] = mk(11, 2, 700, 6, 13, 4'h8, 0, 0);
        mem[41] = mk(12, 3, 800, 0, 14, 4'hf, 1, 0);
        mem[42] = mk(15, 3, 720, 12, 16, 4'hb, 1, 1);
        run_prog(8'd40, 1'b0, 1'b0);

        // asynchronous reset in the middle of ACC
        mem[50] = mk(200, 5, 900, 16, 250, 4'hc, 1, 1);
        @(negedge clk);
        start_addr = 8'd50; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        t = 0;
        while (!mac_acc_update && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mac", mac_acc_update, 0);
        chk("arst_wen", xy_write_enable, 0);
        chk("arst_waddr", xy_write_addr, 0);
        chk("arst_mask", act_mask, 0);
        chk("arst_xaddr", xy_read_addr, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            s  = 8'($urandom);
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                idx = s + 8'(l);
                d.x_offset     = 10'($urandom);
                d.x_length     = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 5));
                d.y_offset     = 10'($urandom);
                d.y_length     = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 20));
                d.w_offset     = 10'($urandom);
                d.act_mask     = 4'($urandom);
                d.output_layer = 1'($urandom);
                d.last         = (l == nl - 1);
                mem[idx] = d;
            end
            run_prog(s, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
